armored40_lock_ctrl: RTL and testbench

Per-lane word-lock supervisor for the armored40 receive path. Watches decoder fix/fail flags in fixed windows and issues single-cycle bitslip pulses to the 40-bit deserializer until the lane is clean, then declares lock. If every slip position fails, it raises a handshaked digital-reset request to the reset sequencer. One instance sits per lane in the recovered-clock domain, between the armored40 decoder and the transceiver bitslip input.

---
 rtl/armored40_lock_pkg.sv | 29 ++
 rtl/armored40_lock_window.sv | 40 ++++
 rtl/armored40_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_armored40_lock_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/armored40_lock_pkg.sv
// Shared types and helpers for the armored40 per-lane word-lock supervisor.
package armored40_lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_OBSERVE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_RESYNC  = 3'd4
   } lock_state_t;

   localparam int unsigned SLIP_W = 6;
   localparam int unsigned LOSS_W = 8;
   localparam int unsigned STAT_W = 16;

   function automatic int unsigned timer_width(input int unsigned win_bits);
      return win_bits;
   endfunction

   // Error counter must hold UNLOCK_THRESH itself, since it saturates there.
   function automatic int unsigned err_width(input int unsigned thresh);
      return $clog2(thresh + 1);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
      return (v >= max) ? max : v + 16'd1;
   endfunction

endpackage

// File: rtl/armored40_lock_window.sv
// Window timer, ping generator and saturating per-window error counter.
module armored40_lock_window
   import armored40_lock_pkg::*;
#(
   parameter int unsigned WIN_BITS      = 4,
   parameter int unsigned UNLOCK_THRESH = 8,
   parameter int unsigned ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             err,
   output logic             ping,
   output logic [ERR_W-1:0] win_errs
);

   localparam int unsigned TIMER_W = timer_width(WIN_BITS);

   logic [TIMER_W-1:0] timer;
   logic [ERR_W-1:0]   err_cnt;

   assign ping = (timer == '1);

   // Includes the current cycle's error so the ping cycle counts toward its window.
   assign win_errs = err ? ERR_W'(sat_inc(16'(err_cnt), 16'(UNLOCK_THRESH))) : err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer   <= '0;
         err_cnt <= '0;
      end else if (restart) begin
         timer   <= '0;
         err_cnt <= '0;
      end else begin
         timer   <= timer + 1'b1;
         err_cnt <= ping ? '0 : win_errs;
      end
   end

endmodule

// File: rtl/armored40_lock_ctrl.sv
// Per-lane word-lock supervisor: slips until clean, declares lock, requests reset.
// Optional statistics counters are enabled by defining ARMORED40_LOCK_STATS_EN.
module armored40_lock_ctrl
   import armored40_lock_pkg::*;
#(
   parameter int unsigned WIN_BITS       = 4,
   parameter int unsigned UNLOCK_THRESH  = 8,
   parameter int unsigned MAX_SLIPS      = 40,
   parameter int unsigned FLUSH_WINDOWS  = 1,
   parameter int unsigned STABLE_WINDOWS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        dec_fix,
   input  logic        dec_fail,
   output logic        bitslip,
   output logic        wordlock,
   output logic        relock_req,
   input  logic        relock_ack,
   output logic [5:0]  slip_count,
   output logic [7:0]  lock_loss_cnt,
   output logic [2:0]  state,
   output logic [15:0] fix_total,
   output logic [15:0] fail_total
);

   localparam int unsigned ERR_W = err_width(UNLOCK_THRESH);
   localparam int unsigned FW_W  = $clog2(FLUSH_WINDOWS + 1);
   localparam int unsigned GW_W  = $clog2(STABLE_WINDOWS + 1);

   lock_state_t     cur_state;
   logic [FW_W-1:0] flush_cnt;
   logic [GW_W-1:0] good_win;
   logic            ping;
   logic [ERR_W-1:0] win_errs;
   logic            restart;

   // Every transition that is not on a ping passes through IDLE/RESYNC or enable=0,
   // so holding the timer there is enough to start each state at timer 0.
   assign restart = !enable || (cur_state == ST_IDLE) || (cur_state == ST_RESYNC);

   armored40_lock_window #(
      .WIN_BITS      (WIN_BITS),
      .UNLOCK_THRESH (UNLOCK_THRESH),
      .ERR_W         (ERR_W)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .restart  (restart),
      .err      (dec_fix | dec_fail),
      .ping     (ping),
      .win_errs (win_errs)
   );

   assign state = cur_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state     <= ST_IDLE;
         bitslip       <= 1'b0;
         wordlock      <= 1'b0;
         relock_req    <= 1'b0;
         slip_count    <= '0;
         lock_loss_cnt <= '0;
         flush_cnt     <= '0;
         good_win      <= '0;
      end else begin
         bitslip <= 1'b0;
         if (!enable) begin
            cur_state  <= ST_IDLE;
            wordlock   <= 1'b0;
            relock_req <= 1'b0;
            slip_count <= '0;
            flush_cnt  <= '0;
            good_win   <= '0;
         end else begin
            case (cur_state)
               ST_IDLE: begin
                  slip_count <= '0;
                  flush_cnt  <= '0;
                  cur_state  <= ST_FLUSH;
               end
               ST_FLUSH: begin
                  if (ping) begin
                     if (flush_cnt == FW_W'(FLUSH_WINDOWS - 1)) begin
                        flush_cnt <= '0;
                        good_win  <= '0;
                        cur_state <= ST_OBSERVE;
                     end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                     end
                  end
               end
               ST_OBSERVE: begin
                  if (ping) begin
                     if (win_errs != '0) begin
                        if (slip_count == SLIP_W'(MAX_SLIPS - 1)) begin
                           relock_req <= 1'b1;
                           cur_state  <= ST_RESYNC;
                        end else begin
                           bitslip    <= 1'b1;
                           slip_count <= slip_count + 1'b1;
                           flush_cnt  <= '0;
                           cur_state  <= ST_FLUSH;
                        end
                     end else if (good_win == GW_W'(STABLE_WINDOWS - 1)) begin
                        wordlock  <= 1'b1;
                        cur_state <= ST_LOCKED;
                     end else begin
                        good_win <= good_win + 1'b1;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (ping && (win_errs >= ERR_W'(UNLOCK_THRESH))) begin
                     wordlock      <= 1'b0;
                     lock_loss_cnt <= LOSS_W'(sat_inc(16'(lock_loss_cnt), 16'd255));
                     slip_count    <= '0;
                     good_win      <= '0;
                     cur_state     <= ST_OBSERVE;
                  end
               end
               ST_RESYNC: begin
                  if (relock_ack) begin
                     relock_req <= 1'b0;
                     slip_count <= '0;
                     flush_cnt  <= '0;
                     cur_state  <= ST_FLUSH;
                  end
               end
               default: cur_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef ARMORED40_LOCK_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fix_total  <= '0;
         fail_total <= '0;
      end else if (cur_state == ST_LOCKED) begin
         if (dec_fix)  fix_total  <= sat_inc(fix_total, 16'hFFFF);
         if (dec_fail) fail_total <= sat_inc(fail_total, 16'hFFFF);
      end
   end
`else
   assign fix_total  = '0;
   assign fail_total = '0;
`endif

endmodule

// File: tb/tb_armored40_lock_ctrl.sv
// Directed scoreboard bench for armored40_lock_ctrl (default parameters, 16-cycle window).
module tb_armored40_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst, enable, dec_fix, dec_fail, relock_ack;
   logic        bitslip, wordlock, relock_req;
   logic [5:0]  slip_count;
   logic [7:0]  lock_loss_cnt;
   logic [2:0]  state;
   logic [15:0] fix_total, fail_total;

   armored40_lock_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .dec_fix       (dec_fix),
      .dec_fail      (dec_fail),
      .bitslip       (bitslip),
      .wordlock      (wordlock),
      .relock_req    (relock_req),
      .relock_ack    (relock_ack),
      .slip_count    (slip_count),
      .lock_loss_cnt (lock_loss_cnt),
      .state         (state),
      .fix_total     (fix_total),
      .fail_total    (fail_total)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pulses = 0;

   function automatic logic [31:0] pk(input logic [2:0] s, input logic wl, input logic bs,
                                      input logic rr, input logic [5:0] sc, input logic [7:0] llc);
      return {12'd0, s, wl, bs, rr, sc, llc};
   endfunction

   function automatic logic [31:0] snap();
      return pk(state, wordlock, bitslip, relock_req, slip_count, lock_loss_cnt);
   endfunction

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bitslip === 1'b1) pulses++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic snap_at(input int n, input string tag, input logic [31:0] v);
      sb_push(tag, v);
      run_to(n);
      check(snap());
   endtask

   logic [31:0] stats_exp;

   initial begin
      rst = 1'b1; enable = 1'b0; dec_fix = 1'b0; dec_fail = 1'b0; relock_ack = 1'b0;
      repeat (2) tick();
      sb_push("reset_outputs", '0);
      check(snap());
      sb_push("reset_stats", '0);
      check({fix_total, fail_total});
      rst = 1'b0;
      repeat (2) tick();

      // Clean acquisition, then LOCKED threshold boundary.
      cyc = 0; pulses = 0; enable = 1'b1;
      snap_at(1,  "flush_entry",   pk(3'd1, 0, 0, 0, 6'd0, 8'd0));
      snap_at(17, "observe_entry", pk(3'd2, 0, 0, 0, 6'd0, 8'd0));
      snap_at(48, "pre_lock",      pk(3'd2, 0, 0, 0, 6'd0, 8'd0));
      snap_at(49, "lock",          pk(3'd3, 1, 0, 0, 6'd0, 8'd0));
      for (int c = 50; c <= 56; c++) begin run_to(c); dec_fail = 1'b1; tick(); dec_fail = 1'b0; end
      snap_at(65, "seven_errs_keep_lock", pk(3'd3, 1, 0, 0, 6'd0, 8'd0));
      for (int c = 66; c <= 72; c++) begin run_to(c); dec_fail = 1'b1; tick(); dec_fail = 1'b0; end
      snap_at(80, "locked_pre_ping", pk(3'd3, 1, 0, 0, 6'd0, 8'd0));
      dec_fail = 1'b1; tick(); dec_fail = 1'b0;
      sb_push("unlock_on_ping_err", pk(3'd2, 0, 0, 0, 6'd0, 8'd1));
      check(snap());
      sb_push("no_slip_on_unlock", 32'd0);
      check(32'(pulses));

      // Persistent errors: 39 slips then reset request.
      pulses = 0; dec_fix = 1'b1;
      snap_at(97,   "first_slip",      pk(3'd1, 0, 1, 0, 6'd1, 8'd1));
      snap_at(1344, "last_observe",    pk(3'd2, 0, 0, 0, 6'd39, 8'd1));
      sb_push("slip_pulses_39", 32'd39);
      check(32'(pulses));
      snap_at(1345, "resync_entry",    pk(3'd4, 0, 0, 1, 6'd39, 8'd1));
      snap_at(1350, "relock_held",     pk(3'd4, 0, 0, 1, 6'd39, 8'd1));
      relock_ack = 1'b1; tick(); relock_ack = 1'b0;
      sb_push("ack_to_flush", pk(3'd1, 0, 0, 0, 6'd0, 8'd1));
      check(snap());
      snap_at(2631, "resync_again",    pk(3'd4, 0, 0, 1, 6'd39, 8'd1));
      run_to(2632);
      enable = 1'b0; relock_ack = 1'b1;
      snap_at(2633, "disable_idle",    pk(3'd0, 0, 0, 0, 6'd0, 8'd1));
      snap_at(2634, "ack_ignored",     pk(3'd0, 0, 0, 0, 6'd0, 8'd1));
      relock_ack = 1'b0; dec_fix = 1'b0; enable = 1'b1;
      snap_at(2655, "mid_observe",     pk(3'd2, 0, 0, 0, 6'd0, 8'd1));
      rst = 1'b1;
      #2;
      sb_push("async_reset", '0);
      check(snap());
      enable = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Single slip, relock, and statistics gating.
      cyc = 0; pulses = 0; enable = 1'b1;
      for (int c = 20; c <= 24; c++) begin run_to(c); dec_fail = 1'b1; tick(); dec_fail = 1'b0; end
      snap_at(32, "slip_pre",  pk(3'd2, 0, 0, 0, 6'd0, 8'd0));
      snap_at(33, "slip_edge", pk(3'd1, 0, 1, 0, 6'd1, 8'd0));
      sb_push("stats_observe_ignored", '0);
      check({fix_total, fail_total});
      snap_at(34, "slip_post", pk(3'd1, 0, 0, 0, 6'd1, 8'd0));
      snap_at(80, "relock_pre", pk(3'd2, 0, 0, 0, 6'd1, 8'd0));
      snap_at(81, "relock",     pk(3'd3, 1, 0, 0, 6'd1, 8'd0));
      for (int c = 83; c <= 85; c++) begin run_to(c); dec_fix = 1'b1; tick(); dec_fix = 1'b0; end
      for (int c = 87; c <= 88; c++) begin run_to(c); dec_fail = 1'b1; tick(); dec_fail = 1'b0; end
      snap_at(90, "locked_with_errs", pk(3'd3, 1, 0, 0, 6'd1, 8'd0));
`ifdef ARMORED40_LOCK_STATS_EN
      stats_exp = {16'd3, 16'd2};
`else
      stats_exp = '0;
`endif
      sb_push("stats_locked", stats_exp);
      check({fix_total, fail_total});
      sb_push("single_slip_pulse", 32'd1);
      check(32'(pulses));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
